// File: rtl/aespim_pkg.sv
// Shared types and helpers for the AES PIM sequencer: command, micro-op and state encodings,
// round-constant seed and GF(2^8) doubling.
package aespim_pkg;

  typedef enum logic [1:0] {
    CmdLoad  = 2'd0,
    CmdStore = 2'd1,
    CmdEnc   = 2'd2,
    CmdDec   = 2'd3
  } aespim_cmd_e;

  typedef enum logic [2:0] {
    OpLd   = 3'd0,
    OpSt   = 3'd1,
    OpKexi = 3'd2,
    OpKex  = 3'd3,
    OpEnci = 3'd4,
    OpEncm = 3'd5,
    OpEncf = 3'd6,
    OpDecm = 3'd7
  } op_code_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StXfer    = 3'd1,
    StKeyInit = 3'd2,
    StEncInit = 3'd3,
    StKex     = 3'd4,
    StEnc     = 3'd5,
    StDec     = 3'd6,
    StDone    = 3'd7
  } aespim_seq_state_e;

  localparam logic [7:0] AESPIM_RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) with reduction polynomial 0x11b.
  function automatic logic [7:0] aespim_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aespim_rcon_gen.sv
// AES key-expansion round-constant register: reloads to 0x01, doubles in GF(2^8) on advance.
module aespim_rcon_gen
  import aespim_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] rcon_o
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rcon <= AESPIM_RCON_INIT;
    end else if (load_i) begin
      r_rcon <= AESPIM_RCON_INIT;
    end else if (adv_i) begin
      r_rcon <= aespim_xtime(r_rcon);
    end
  end

  assign rcon_o = r_rcon;

endmodule

// File: rtl/aespim_round_seq.sv
// Expands LOAD/STORE/ENC/DEC commands into the AES PIM micro-op stream over valid/ready.
// Optional stall counter enabled by defining AESPIM_STALL_CNT_EN.
module aespim_round_seq
  import aespim_pkg::*;
#(
  parameter int unsigned NumRounds = 10,
  parameter int unsigned NumWords  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic        dp_valid_o,
  input  logic        dp_ready_i,
  output logic [2:0]  dp_op_o,
  output logic [3:0]  dp_round_o,
  output logic [1:0]  dp_word_o,
  output logic [7:0]  dp_rcon_o,
  output logic [15:0] stall_cnt_o
);

  if (NumRounds != 10) begin : g_bad_rounds
    $error("aespim_round_seq: NumRounds must be 10");
  end
  if (NumWords < 1 || NumWords > 4) begin : g_bad_words
    $error("aespim_round_seq: NumWords must be 1..4");
  end

  localparam logic [3:0] LastRound = 4'(NumRounds);
  localparam logic [1:0] LastWord  = 2'(NumWords - 1);

  aespim_seq_state_e r_state;
  logic [3:0]        r_round;
  logic [1:0]        r_word;
  logic              r_is_store;
  logic [7:0]        w_rcon;
  logic              w_issue;
  logic              w_accept;
  logic              w_hs;
  aespim_cmd_e       w_cmd;

  assign w_cmd    = aespim_cmd_e'(cmd_i);
  assign w_issue  = (r_state != StIdle) && (r_state != StDone);
  assign w_accept = (r_state == StIdle) && cmd_valid_i;
  assign w_hs     = w_issue && dp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_round    <= '0;
      r_word     <= '0;
      r_is_store <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_valid_i) begin
            r_round    <= '0;
            r_word     <= '0;
            r_is_store <= (w_cmd == CmdStore);
            unique case (w_cmd)
              CmdLoad, CmdStore: r_state <= StXfer;
              CmdEnc:            r_state <= StKeyInit;
              CmdDec: begin
                r_state <= StDec;
                r_round <= LastRound;
              end
              default:           r_state <= StIdle;
            endcase
          end
        end
        StDone: r_state <= StIdle;
        default: begin
          // An accepted micro-op coinciding with abort still completes; nothing follows it.
          if (abort_i) begin
            r_state <= StIdle;
          end else if (dp_ready_i) begin
            unique case (r_state)
              StXfer: begin
                if (r_word == LastWord) r_state <= StDone;
                else r_word <= r_word + 2'd1;
              end
              StKeyInit: r_state <= StEncInit;
              StEncInit: begin
                r_state <= StKex;
                r_round <= 4'd1;
              end
              StKex: r_state <= StEnc;
              StEnc: begin
                if (r_round == LastRound) begin
                  r_state <= StDone;
                end else begin
                  r_state <= StKex;
                  r_round <= r_round + 4'd1;
                end
              end
              StDec: begin
                if (r_round == 4'd1) r_state <= StDone;
                else r_round <= r_round - 4'd1;
              end
              default: r_state <= r_state;
            endcase
          end
        end
      endcase
    end
  end

  aespim_rcon_gen u_rcon_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_accept),
    .adv_i  (w_hs && (r_state == StKex)),
    .rcon_o (w_rcon)
  );

  always_comb begin
    dp_op_o = OpLd;
    unique case (r_state)
      StXfer:    dp_op_o = r_is_store ? OpSt : OpLd;
      StKeyInit: dp_op_o = OpKexi;
      StEncInit: dp_op_o = OpEnci;
      StKex:     dp_op_o = OpKex;
      StEnc:     dp_op_o = (r_round == LastRound) ? OpEncf : OpEncm;
      StDec:     dp_op_o = OpDecm;
      default:   dp_op_o = OpLd;
    endcase
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign busy_o      = (r_state != StIdle);
  assign done_o      = (r_state == StDone);
  assign aborted_o   = w_issue && abort_i;
  assign dp_valid_o  = w_issue;
  assign dp_round_o  = w_issue ? r_round : 4'd0;
  assign dp_word_o   = (r_state == StXfer) ? r_word : 2'd0;
  assign dp_rcon_o   = (r_state == StKex) ? w_rcon : 8'h00;

`ifdef AESPIM_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_accept) begin
      r_stall_cnt <= '0;
    end else if (w_issue && !dp_ready_i && (r_stall_cnt != 16'hffff)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
